hilo_acc: RTL and testbench

HILO_ACC -- requirements
Module: hilo_acc

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/hilo_addsub.sv | 20 ++
 rtl/hilo_acc.sv | 173 +++++++++++++++++
 tb/tb_hilo_acc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO accumulator: result-mode encoding and FSM states.
package hilo_pkg;

  // Result mode carried on ext_op; 2'b11 is handled as a plain write.
  typedef enum logic [1:0] {
    EXT_WRITE = 2'b00,
    EXT_ADD   = 2'b01,
    EXT_SUB   = 2'b10
  } ext_op_e;

  // Accumulate sequencing: product captured in ACC, sum captured in WB.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    WB   = 2'b10
  } state_e;

  // True for the two modes that start a multi-cycle accumulate.
  function automatic logic is_accum(input logic [1:0] op);
    return (op == EXT_ADD) || (op == EXT_SUB);
  endfunction

endpackage

// File: rtl/hilo_addsub.sv
// Combinational W-bit adder/subtractor, result modulo 2^W, no flags.
module hilo_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  // Select a+b or a-b; wrap-around is the intended behaviour.
  always_comb begin
    if (sub_i) begin
      y_o = a_i - b_i;
    end else begin
      y_o = a_i + b_i;
    end
  end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO architectural register pair with MTHI/MTLO writes, mul/div result
// writes and a two-stage multiply-accumulate (MADD/MSUB) with flush support.
module hilo_acc
  import hilo_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_finish,
  input  logic [1:0]        ext_op,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  input  logic              hi_wr,
  input  logic              lo_wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              ovr_err
);

  localparam int PW = 2 * DATA_W;

  state_e            state_q, state_d;
  ext_op_e           op_q, op_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [PW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              ovr_q, ovr_d;
  logic [PW-1:0]     addsub_y;
  logic              any_req;

  assign any_req = md_finish | hi_wr | lo_wr;

  hilo_addsub #(
    .W (PW)
  ) u_addsub (
    .a_i   ({hi_q, lo_q}),
    .b_i   (prod_q),
    .sub_i (op_q == EXT_SUB),
    .y_o   (addsub_y)
  );

  // FSM state register; reset aborts any accumulate in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: flush always returns to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (!flush && md_finish && is_accum(ext_op)) begin
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: any non-IDLE state blocks new writes.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      ACC:     busy = 1'b1;
      WB:      busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath next-state: HI/LO writes, product/sum capture, sticky overrun.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    prod_d = prod_q;
    op_d   = op_q;
    sum_d  = sum_q;
    // A flushed request never counts as an overrun.
    if (busy && !flush && any_req) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
    case (state_q)
      IDLE: begin
        if (flush) begin
          hi_d = hi_q;
        end else if (md_finish) begin
          // md_finish has priority; a concurrent MTHI/MTLO is dropped.
          if (is_accum(ext_op)) begin
            prod_d = {md_hi, md_lo};
            op_d   = ext_op_e'(ext_op);
          end else begin
            hi_d = md_hi;
            lo_d = md_lo;
          end
        end else begin
          if (hi_wr) begin
            hi_d = wr_data;
          end else begin
            hi_d = hi_q;
          end
          if (lo_wr) begin
            lo_d = wr_data;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      ACC: begin
        if (!flush) begin
          sum_d = addsub_y;
        end else begin
          sum_d = sum_q;
        end
      end
      WB: begin
        if (!flush) begin
          {hi_d, lo_d} = sum_q;
        end else begin
          hi_d = hi_q;
        end
      end
      default: begin
        hi_d = hi_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= RST_VAL;
      lo_q   <= RST_VAL;
      prod_q <= '0;
      sum_q  <= '0;
      op_q   <= EXT_WRITE;
      ovr_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      op_q   <= op_d;
      ovr_q  <= ovr_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign ovr_err = ovr_q;

endmodule

// File: tb/tb_hilo_acc.sv
// Directed self-checking bench for hilo_acc (DATA_W=32, RST_VAL=0).
module tb_hilo_acc;

  logic        clk;
  logic        rst;
  logic        md_finish;
  logic [1:0]  ext_op;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        ovr_err;

  int checks;
  int errors;

  hilo_acc dut (
    .clk       (clk),
    .rst       (rst),
    .md_finish (md_finish),
    .ext_op    (ext_op),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .hi_wr     (hi_wr),
    .lo_wr     (lo_wr),
    .wr_data   (wr_data),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .ovr_err   (ovr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    md_finish = 1'b0; ext_op = 2'b00; md_hi = 32'h0; md_lo = 32'h0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = 32'h0; flush = 1'b0;
  endtask

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    hi_wr = 1'b1; wr_data = h; tick();
    hi_wr = 1'b0; lo_wr = 1'b1; wr_data = l; tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo hi=%h lo=%h exp 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || ovr_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b ovr=%b exp 0/0", busy, ovr_err);
    end
    md_finish = 1'b1; ext_op = 2'b00; md_hi = 32'h1234_5678; md_lo = 32'h9ABC_DEF0;
    #1;
    rst = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL first_write hi=%h lo=%h exp 12345678/9abcdef0", hi, lo);
    end
  endtask

  task automatic test_mt_writes();
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h5555_AAAA;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h5555_AAAA || lo !== 32'h5555_AAAA) begin
      errors++; $display("FAIL mt_both hi=%h lo=%h exp 5555aaaa/5555aaaa", hi, lo);
    end
    md_finish = 1'b1; ext_op = 2'b11; md_hi = 32'h0000_0011; md_lo = 32'h0000_0022;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
      errors++; $display("FAIL op11_write hi=%h lo=%h busy=%b exp 11/22/0", hi, lo, busy);
    end
  endtask

  task automatic test_madd_carry();
    load_hilo(32'h0, 32'hFFFF_FFFF);
    md_finish = 1'b1; ext_op = 2'b01; md_hi = 32'h0; md_lo = 32'h1;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL madd_acc busy=%b hi=%h lo=%h exp 1/0/ffffffff", busy, hi, lo);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL madd_wb busy=%b hi=%h lo=%h exp 1/0/ffffffff", busy, hi, lo);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h0) begin
      errors++; $display("FAIL madd_done busy=%b hi=%h lo=%h exp 0/1/0", busy, hi, lo);
    end
  endtask

  task automatic test_msub_wrap();
    load_hilo(32'h0, 32'h0);
    md_finish = 1'b1; ext_op = 2'b10; md_hi = 32'h0; md_lo = 32'h1;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL msub_wrap busy=%b hi=%h lo=%h exp 0/ffffffff/ffffffff", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    // hi/lo = ffffffff_ffffffff; + 2 wraps to 00000000_00000001.
    checks++;
    if (ovr_err !== 1'b0) begin
      errors++; $display("FAIL ovr_pre ovr=%b exp 0", ovr_err);
    end
    md_finish = 1'b1; ext_op = 2'b01; md_hi = 32'h0; md_lo = 32'h2;
    tick();
    idle_inputs();
    hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++;
    if (ovr_err !== 1'b1 || busy !== 1'b1 || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL ovr_set ovr=%b busy=%b hi=%h exp 1/1/ffffffff", ovr_err, busy, hi);
    end
    tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h1 || busy !== 1'b0) begin
      errors++; $display("FAIL ovr_sum hi=%h lo=%h busy=%b exp 0/1/0", hi, lo, busy);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ovr_err !== 1'b1 || hi !== 32'h0 || lo !== 32'h1) begin
      errors++; $display("FAIL ovr_sticky ovr=%b hi=%h lo=%h exp 1/0/1", ovr_err, hi, lo);
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    checks++;
    if (ovr_err !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL ovr_clear ovr=%b hi=%h lo=%h exp 0/0/0", ovr_err, hi, lo);
    end
  endtask

  task automatic test_flush();
    load_hilo(32'h7, 32'h9);
    md_finish = 1'b1; ext_op = 2'b01; md_hi = 32'h0; md_lo = 32'h1;
    tick();
    idle_inputs();
    flush = 1'b1; hi_wr = 1'b1; wr_data = 32'h3;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || ovr_err !== 1'b0 || hi !== 32'h7 || lo !== 32'h9) begin
      errors++; $display("FAIL flush_acc busy=%b ovr=%b hi=%h lo=%h exp 0/0/7/9", busy, ovr_err, hi, lo);
    end
    tick();
    tick();
    checks++;
    if (hi !== 32'h7 || lo !== 32'h9) begin
      errors++; $display("FAIL flush_hold hi=%h lo=%h exp 7/9", hi, lo);
    end
    flush = 1'b1; md_finish = 1'b1; ext_op = 2'b00; md_hi = 32'h44; md_lo = 32'h55;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h7 || lo !== 32'h9 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle hi=%h lo=%h busy=%b exp 7/9/0", hi, lo, busy);
    end
    md_finish = 1'b1; ext_op = 2'b00; md_hi = 32'hA; md_lo = 32'hC;
    hi_wr = 1'b1; wr_data = 32'hB;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'hA || lo !== 32'hC || ovr_err !== 1'b0) begin
      errors++; $display("FAIL md_priority hi=%h lo=%h ovr=%b exp a/c/0", hi, lo, ovr_err);
    end
  endtask

  task automatic test_rst_wb();
    md_finish = 1'b1; ext_op = 2'b01; md_hi = 32'h0; md_lo = 32'h100;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (busy !== 1'b1 || hi !== 32'hA) begin
      errors++; $display("FAIL rst_wb_pre busy=%b hi=%h exp 1/a", busy, hi);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_wb_async hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_wb_nosum hi=%h lo=%h busy=%b exp 0/0/0", hi, lo, busy);
    end
    lo_wr = 1'b1; wr_data = 32'h77;
    tick();
    idle_inputs();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h77) begin
      errors++; $display("FAIL post_rst_wr hi=%h lo=%h exp 0/77", hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mt_writes();
    test_madd_carry();
    test_msub_wrap();
    test_back_to_back();
    test_flush();
    test_rst_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
